// File: rtl/me_stage.sv
// RV32I memory-access stage: aligns loads/stores onto a request/ready data bus
// and forwards registered results to ME/WB, stalling upstream while busy.
module me_stage #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       val_out,
    input  logic              reg_w,
    input  logic [31:0]       reg_data,
    input  logic              mem_w,
    input  logic              mem_r,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic [1:0]        mem_len,
    input  logic              mem_uns,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [31:0]       wb_val,
    output logic              wb_reg_w,
    output logic [31:0]       wb_reg_data,
    output logic              misalign
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                wb_valid_q, wb_valid_d, wb_reg_w_q, wb_reg_w_d;
    logic [31:0]         wb_val_q, wb_val_d, wb_reg_data_q, wb_reg_data_d;
    logic                misalign_q, misalign_d;
    logic [31:0]         c_val_q, c_val_d, c_reg_data_q, c_reg_data_d;
    logic                c_reg_w_q, c_reg_w_d, c_uns_q, c_uns_d, c_load_q, c_load_d;
    logic [1:0]          c_len_q, c_len_d, c_off_q, c_off_d;

    logic                aligned_c, go_c;
    logic [31:0]         lane_wdata_c, load_ext_c;
    logic [3:0]          lane_wstrb_c;
    logic [7:0]          ld_byte_c;
    logic [15:0]         ld_half_c;

    // Legality of the incoming access
    always_comb begin
        unique case (mem_len)
            2'b00:   aligned_c = 1'b1;
            2'b01:   aligned_c = ~mem_addr[0];
            2'b10:   aligned_c = (mem_addr[1:0] == 2'b00);
            default: aligned_c = 1'b0;
        endcase
    end

    assign go_c = (mem_r ^ mem_w) & aligned_c;

    // Store lane replication and byte strobes
    always_comb begin
        unique case (mem_len)
            2'b00: begin
                lane_wdata_c = {4{mem_data[7:0]}};
                lane_wstrb_c = 4'(4'b0001 << mem_addr[1:0]);
            end
            2'b01: begin
                lane_wdata_c = {2{mem_data[15:0]}};
                lane_wstrb_c = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata_c = mem_data;
                lane_wstrb_c = 4'b1111;
            end
        endcase
        if (mem_r) lane_wstrb_c = 4'b0000;
    end

    // Load lane extraction and extension
    always_comb begin
        unique case (c_off_q)
            2'd0:    ld_byte_c = dmem_rdata[7:0];
            2'd1:    ld_byte_c = dmem_rdata[15:8];
            2'd2:    ld_byte_c = dmem_rdata[23:16];
            default: ld_byte_c = dmem_rdata[31:24];
        endcase
        ld_half_c = c_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (c_len_q)
            2'b00:   load_ext_c = {{24{~c_uns_q & ld_byte_c[7]}}, ld_byte_c};
            2'b01:   load_ext_c = {{16{~c_uns_q & ld_half_c[15]}}, ld_half_c};
            default: load_ext_c = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        wb_valid_d    = 1'b0;
        misalign_d    = 1'b0;
        wb_val_d      = wb_val_q;
        wb_reg_w_d    = wb_reg_w_q;
        wb_reg_data_d = wb_reg_data_q;
        c_val_d       = c_val_q;
        c_reg_data_d  = c_reg_data_q;
        c_reg_w_d     = c_reg_w_q;
        c_uns_d       = c_uns_q;
        c_load_d      = c_load_q;
        c_len_d       = c_len_q;
        c_off_d       = c_off_q;
        unique case (state_q)
            S_IDLE: begin
                if (go_c) begin
                    state_d      = S_WAIT;
                    req_d        = 1'b1;
                    we_d         = mem_w;
                    addr_d       = {mem_addr[ADDR_W-1:2], 2'b00};
                    wdata_d      = lane_wdata_c;
                    wstrb_d      = lane_wstrb_c;
                    c_val_d      = val_out;
                    c_reg_data_d = reg_data;
                    c_reg_w_d    = reg_w;
                    c_uns_d      = mem_uns;
                    c_load_d     = mem_r;
                    c_len_d      = mem_len;
                    c_off_d      = mem_addr[1:0];
                end else if (mem_r | mem_w) begin
                    misalign_d    = 1'b1;
                    wb_valid_d    = 1'b1;
                    wb_reg_w_d    = 1'b0;
                    wb_val_d      = val_out;
                    wb_reg_data_d = reg_data;
                end else begin
                    wb_valid_d    = 1'b1;
                    wb_val_d      = val_out;
                    wb_reg_w_d    = reg_w;
                    wb_reg_data_d = reg_data;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    state_d       = S_IDLE;
                    req_d         = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_val_d      = c_load_q ? load_ext_c : c_val_q;
                    wb_reg_w_d    = c_reg_w_q;
                    wb_reg_data_d = c_reg_data_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wb_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            wb_val_q      <= '0;
            wb_reg_w_q    <= 1'b0;
            wb_reg_data_q <= '0;
            c_val_q       <= '0;
            c_reg_data_q  <= '0;
            c_reg_w_q     <= 1'b0;
            c_uns_q       <= 1'b0;
            c_load_q      <= 1'b0;
            c_len_q       <= '0;
            c_off_q       <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            wb_valid_q    <= wb_valid_d;
            misalign_q    <= misalign_d;
            wb_val_q      <= wb_val_d;
            wb_reg_w_q    <= wb_reg_w_d;
            wb_reg_data_q <= wb_reg_data_d;
            c_val_q       <= c_val_d;
            c_reg_data_q  <= c_reg_data_d;
            c_reg_w_q     <= c_reg_w_d;
            c_uns_q       <= c_uns_d;
            c_load_q      <= c_load_d;
            c_len_q       <= c_len_d;
            c_off_q       <= c_off_d;
        end
    end

    // Held low during reset so upstream is never frozen by a discarded access
    assign stall = rst_n & (((state_q == S_IDLE) & go_c) | ((state_q == S_WAIT) & ~dmem_ready));

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_wstrb  = wstrb_q;
    assign wb_valid    = wb_valid_q;
    assign wb_val      = wb_val_q;
    assign wb_reg_w    = wb_reg_w_q;
    assign wb_reg_data = wb_reg_data_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_me_stage.sv
// Bench for me_stage: directed and random memory ops checked against a reference model.
module tb_me_stage;

    logic        clk, rst_n;
    logic [31:0] val_out, reg_data, mem_data, dmem_rdata;
    logic [31:0] mem_addr;
    logic        reg_w, mem_w, mem_r, mem_uns, dmem_ready;
    logic [1:0]  mem_len;
    logic        dmem_req, dmem_we, stall, wb_valid, wb_reg_w, misalign;
    logic [31:0] dmem_addr, dmem_wdata, wb_val, wb_reg_data;
    logic [3:0]  dmem_wstrb;

    int total = 0;
    int bad   = 0;

    me_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .val_out(val_out), .reg_w(reg_w), .reg_data(reg_data),
        .mem_w(mem_w), .mem_r(mem_r), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_len(mem_len), .mem_uns(mem_uns), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_val(wb_val), .wb_reg_w(wb_reg_w),
        .wb_reg_data(wb_reg_data), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: value written back for a load of rdata
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off,
                                             input logic [1:0] len, input bit uns);
        logic [31:0] v;
        v = rdata >> (8 * off);
        if (len == 2'b00) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (len == 2'b01) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic scramble_inputs();
        val_out  = $urandom; reg_data = $urandom; mem_addr = $urandom; mem_data = $urandom;
        mem_len  = 2'($urandom); mem_uns = 1'($urandom); reg_w = 1'($urandom);
        mem_r    = 1'($urandom); mem_w = 1'($urandom);
    endtask

    // Drives one EX/ME instruction at a negedge and checks it through to writeback
    task automatic run_op(input bit r, input bit w, input logic [1:0] len, input bit uns,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] vo, input bit rw, input logic [31:0] rd,
                          input logic [31:0] rdat, input int dly);
        bit          legal;
        int          off;
        logic [31:0] exp_wd, exp_val;
        logic [3:0]  exp_st;
        off   = int'(addr[1:0]);
        legal = (r != w) && (len == 2'b00 || (len == 2'b01 && off % 2 == 0) ||
                             (len == 2'b10 && off == 0));
        mem_r = r; mem_w = w; mem_len = len; mem_uns = uns; mem_addr = addr;
        mem_data = data; val_out = vo; reg_w = rw; reg_data = rd; dmem_ready = 1'b0;
        #1;
        if (!r && !w) begin
            chk("nm_stall", stall, 0);
            @(negedge clk);
            chk("nm_valid", wb_valid, 1); chk("nm_val", wb_val, vo);
            chk("nm_regw", wb_reg_w, rw); chk("nm_rd", wb_reg_data, rd);
            chk("nm_req", dmem_req, 0); chk("nm_mis", misalign, 0);
        end else if (!legal) begin
            chk("il_stall", stall, 0);
            @(negedge clk);
            chk("il_mis", misalign, 1); chk("il_valid", wb_valid, 1);
            chk("il_regw", wb_reg_w, 0); chk("il_req", dmem_req, 0);
        end else begin
            if (len == 2'b00)      begin exp_wd = (data & 32'hFF) * 32'h0101_0101; exp_st = 4'(1 << off); end
            else if (len == 2'b01) begin exp_wd = (data & 32'hFFFF) * 32'h0001_0001; exp_st = 4'(3 << off); end
            else                   begin exp_wd = data; exp_st = 4'hF; end
            if (r) exp_st = 4'h0;
            exp_val = r ? ref_load(rdat, off, len, uns) : vo;
            chk("ac_stall0", stall, 1);
            @(negedge clk);
            scramble_inputs();
            chk("ac_req", dmem_req, 1); chk("ac_we", dmem_we, w);
            chk("ac_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            chk("ac_strb", dmem_wstrb, exp_st);
            if (w) chk("ac_wdata", dmem_wdata, exp_wd);
            chk("ac_wbv0", wb_valid, 0);
            for (int i = 0; i < dly; i++) begin
                #1 chk("wt_stall", stall, 1);
                @(negedge clk);
                chk("wt_req", dmem_req, 1); chk("wt_wbv", wb_valid, 0);
                chk("wt_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            end
            dmem_ready = 1'b1;
            dmem_rdata = rdat;
            #1 chk("rd_stall", stall, 0);
            @(negedge clk);
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
            chk("cp_valid", wb_valid, 1); chk("cp_val", wb_val, exp_val);
            chk("cp_regw", wb_reg_w, rw); chk("cp_rd", wb_reg_data, rd);
            chk("cp_req", dmem_req, 0); chk("cp_mis", misalign, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
        val_out = '0; reg_w = 1'b0; reg_data = '0; mem_w = 1'b0; mem_r = 1'b0;
        mem_addr = '0; mem_data = '0; mem_len = 2'b00; mem_uns = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_req", dmem_req, 0); chk("rst_valid", wb_valid, 0);
        chk("rst_mis", misalign, 0); chk("rst_strb", dmem_wstrb, 0);
        chk("rst_val", wb_val, 0); chk("rst_addr", dmem_addr, 0);
        rst_n = 1'b1;

        run_op(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h1234, 1, 32'h7, 32'h0, 0);
        run_op(0, 1, 2'b00, 0, 32'h1003, 32'hAB, 32'h55, 0, 32'h9, 32'h0, 2);
        run_op(1, 0, 2'b01, 0, 32'h2002, 32'h0, 32'h1, 1, 32'hA, 32'h8001_0000, 1);
        run_op(1, 0, 2'b01, 1, 32'h2002, 32'h0, 32'h2, 1, 32'hB, 32'h8001_0000, 0);
        run_op(1, 0, 2'b10, 0, 32'h3001, 32'h0, 32'h3, 1, 32'hC, 32'h0, 0);
        run_op(1, 0, 2'b11, 0, 32'h3000, 32'h0, 32'h4, 1, 32'hD, 32'h0, 0);
        run_op(1, 1, 2'b10, 0, 32'h3000, 32'h0, 32'h5, 1, 32'hE, 32'h0, 0);
        run_op(1, 0, 2'b00, 0, 32'h4001, 32'h0, 32'h6, 1, 32'hF, 32'h1122_F344, 0);
        run_op(1, 0, 2'b10, 0, 32'h4004, 32'h0, 32'h7, 1, 32'h10, 32'hDEAD_BEEF, 0);

        // Reset while a load is outstanding
        mem_r = 1'b1; mem_w = 1'b0; mem_len = 2'b10; mem_addr = 32'h5000;
        @(negedge clk);
        chk("prst_req", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1 chk("mrst_req", dmem_req, 0); chk("mrst_stall", stall, 0);
        mem_r = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'hCAFE, 1, 32'h11, 32'h0, 0);

        for (int n = 0; n < 80; n++) begin
            int          kind;
            logic [1:0]  len;
            logic [31:0] a;
            kind = int'($urandom_range(0, 4));
            len  = 2'($urandom_range(0, 2));
            a    = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            case (kind)
                0: run_op(0, 0, len, 1'($urandom), a, $urandom, $urandom, 1'($urandom), $urandom, $urandom, 0);
                1: run_op(1, 0, len, 1'($urandom), a, $urandom, $urandom, 1'($urandom), $urandom, $urandom,
                          int'($urandom_range(0, 3)));
                2: run_op(0, 1, len, 1'($urandom), a, $urandom, $urandom, 1'($urandom), $urandom, $urandom,
                          int'($urandom_range(0, 3)));
                3: run_op(1, 1, len, 1'($urandom), a, $urandom, $urandom, 1'($urandom), $urandom, $urandom, 0);
                default: run_op(1'($urandom), 1'($urandom), 2'b11, 1'($urandom), a, $urandom, $urandom,
                                1'($urandom), $urandom, $urandom, 0);
            endcase
        end

        mem_r = 1'b0; mem_w = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/me_stage.md
Name: me_stage

Overview:
- Memory-access stage of the RV32I pipeline, directly downstream of the EX/ME pipeline register.
- Consumes the registered EX/ME outputs and performs loads and stores over a data-memory request/ready bus.
- Applies byte-lane alignment, store strobes and load sign/zero extension.
- Drives registered results towards ME/WB and raises a stall to the hazard logic while an access is outstanding.

Parameters:
- ADDR_W, 32, width of mem_addr and dmem_addr.

Ports:
- clk  in  1  single pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- val_out  in  32  ALU result from EX/ME.
- reg_w  in  1  register write enable from EX/ME.
- reg_data  in  32  writeback tag/data, passed through unchanged.
- mem_w  in  1  store request.
- mem_r  in  1  load request.
- mem_addr  in  ADDR_W  byte address.
- mem_data  in  32  store data, right-justified.
- mem_len  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- mem_uns  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- dmem_req  out  1  bus request; held until accepted.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte write strobes; 0000 on reads.
- dmem_ready  in  1  bus accepts/completes the request this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ready=1 on a read.
- stall  out  1  combinational; upstream must hold its inputs while 1.
- wb_valid  out  1  ME/WB result valid, one-cycle pulse per instruction.
- wb_val  out  32  loaded data or val_out.
- wb_reg_w  out  1  writeback enable.
- wb_reg_data  out  32  reg_data passed through.
- misalign  out  1  one-cycle pulse: misaligned or illegal access.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - dmem_req, dmem_we, dmem_wstrb, wb_valid, wb_reg_w and misalign go to 0.
  - dmem_addr, dmem_wdata, wb_val and wb_reg_data go to 0.
  - A reset mid-access drops dmem_req immediately; the access is discarded.
- State machine has two states, IDLE and WAIT.
- IDLE, neither mem_r nor mem_w set:
  - Next edge: wb_val=val_out, wb_reg_w=reg_w, wb_reg_data=reg_data, wb_valid=1.
  - Latency is 1 cycle; stall=0.
- IDLE, exactly one of mem_r/mem_w set, access aligned:
  - stall=1 this cycle.
  - Next edge: register dmem_req=1, dmem_we=mem_w, dmem_addr={addr[ADDR_W-1:2],2'b00}, dmem_wdata, dmem_wstrb, and the instruction context; go to WAIT.
- Alignment is legal when:
  - byte: any address;
  - half: addr[0]=0;
  - word: addr[1:0]=0;
  - mem_len=11 is always illegal.
- Illegal access, or mem_r and mem_w both set:
  - No bus request.
  - Next edge: misalign=1, wb_valid=1, wb_reg_w=0; stall=0.
- Store lanes:
  - byte: wdata={4{mem_data[7:0]}}, wstrb=0001<<addr[1:0].
  - half: wdata={2{mem_data[15:0]}}, wstrb=0011 (addr[1]=0) or 1100 (addr[1]=1).
  - word: wdata=mem_data, wstrb=1111.
- WAIT:
  - dmem_req and all dmem_* outputs are held stable.
  - stall = ~dmem_ready.
  - On the dmem_ready=1 edge: dmem_req→0, state→IDLE, wb_valid=1, wb_reg_w=captured reg_w, wb_reg_data=captured reg_data.
  - Load: wb_val=extended data. Store: wb_val=captured val_out.
  - EX/ME inputs are ignored while in WAIT.
- Load extraction:
  - byte = rdata[8*addr[1:0] +: 8].
  - half = rdata[16*addr[1] +: 16].
  - Sign-extend from the MSB unless mem_uns=1; word loads pass through.
- Aligned-access latency:
  - Request visible 1 cycle after capture.
  - Result in wb_* 1 cycle after the dmem_ready cycle.
  - Minimum 3 cycles with ready asserted immediately.
- Back-to-back: in the cycle after a completion, IDLE evaluates fresh inputs normally.
- wb_valid and misalign are 0 in every cycle not listed above.
- dmem_ready while in IDLE is ignored.

Test Plan:
- Non-memory op, val_out=0x1234, reg_w=1 → next cycle wb_valid=1, wb_val=0x1234, wb_reg_w=1, stall=0, dmem_req=0.
- Store byte, addr=0x1003, data=0xAB, ready after 2 WAIT cycles → dmem_addr=0x1000, wstrb=1000, wdata=0xABABABAB, stall=1 for 3 cycles, then wb_valid=1.
- Load half, addr=0x2002, rdata=0x8001_0000: mem_uns=0 → wb_val=0xFFFF8001; mem_uns=1 → wb_val=0x00008001.
- Load word, addr=0x3001 → no dmem_req, misalign=1 and wb_valid=1 with wb_reg_w=0 next cycle; mem_len=11 at any address gives the same result.
- Load pending in WAIT, assert rst_n=0 → dmem_req=0 immediately, stall=0, state IDLE; after release, a non-memory op completes normally.
- Two back-to-back loads, byte then word, with dmem_ready asserted in the first WAIT cycle → each completes in 3 cycles with the correct wb_val order and no lost or duplicated wb_valid.
